// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer scan address generator.
//   DefHRes/DefVRes : default frame size in pixels
//   DefXw/DefYw/DefAw : default coordinate and linear address widths
//   scan_state_e    : scanner state encoding
package fb_pkg;

  localparam int unsigned DefHRes = 320;
  localparam int unsigned DefVRes = 240;
  localparam int unsigned DefXw   = 10;
  localparam int unsigned DefYw   = 9;
  localparam int unsigned DefAw   = 17;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun
  } scan_state_e;

endpackage

// File: rtl/fb_scan_addr_if.sv
// Control and beat-stream bundle of the scan address generator.
//   start/cont/stop         : scan control (master -> slave)
//   win_x0/x1, win_y0/y1    : inclusive window bounds (master -> slave)
//   addr_ready              : consumer accepts current beat (master -> slave)
//   addr_valid/x/y/addr     : current beat (slave -> master)
//   line_end/frame_end      : beat position flags (slave -> master)
//   busy/done/cfg_err       : scanner status (slave -> master)
interface fb_scan_addr_if
  import fb_pkg::*;
#(
  parameter int unsigned XW = DefXw,
  parameter int unsigned YW = DefYw,
  parameter int unsigned AW = DefAw
);

  logic          start;
  logic          cont;
  logic          stop;
  logic [XW-1:0] win_x0;
  logic [XW-1:0] win_x1;
  logic [YW-1:0] win_y0;
  logic [YW-1:0] win_y1;
  logic          addr_ready;

  logic          addr_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr;
  logic          line_end;
  logic          frame_end;
  logic          busy;
  logic          done;
  logic          cfg_err;

  modport master (
    output start, cont, stop, win_x0, win_x1, win_y0, win_y1, addr_ready,
    input  addr_valid, x, y, addr, line_end, frame_end, busy, done, cfg_err
  );

  modport slave (
    input  start, cont, stop, win_x0, win_x1, win_y0, win_y1, addr_ready,
    output addr_valid, x, y, addr, line_end, frame_end, busy, done, cfg_err
  );

endinterface

// File: rtl/fb_base_calc.sv
// Iterative window base address calculator: result = y0 * H_RES + x0.
// Adds H_RES once per cycle instead of using a multiplier, so a request
// takes y0 + 1 cycles from start_i to done_o.
//   clk, reset : clock, asynchronous active-high reset
//   start_i    : load x0_i/y0_i and begin (ignored while busy)
//   abort_i    : drop an in-progress calculation
//   x0_i, y0_i : window origin
//   busy_o     : calculation in progress
//   done_o     : result_o is final this cycle; the unit goes idle on the next edge
//   result_o   : accumulator value
module fb_base_calc
  import fb_pkg::*;
#(
  parameter int unsigned H_RES = DefHRes,
  parameter int unsigned XW    = DefXw,
  parameter int unsigned YW    = DefYw,
  parameter int unsigned AW    = DefAw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [XW-1:0] x0_i,
  input  logic [YW-1:0] y0_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] result_o
);

  logic          busy_q, busy_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [YW-1:0] cnt_q, cnt_d;
  logic [YW-1:0] y0_q, y0_d;
  logic          last_row;

  // Accumulator already holds y0 rows' worth of H_RES plus x0.
  assign last_row = (cnt_q == y0_q);

  always_comb begin
    busy_d = busy_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    y0_d   = y0_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        acc_d  = AW'(x0_i);
        cnt_d  = '0;
        y0_d   = y0_i;
      end
    end else if (abort_i || last_row) begin
      busy_d = 1'b0;
    end else begin
      acc_d = acc_q + AW'(H_RES);
      cnt_d = cnt_q + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      y0_q   <= '0;
    end else begin
      busy_q <= busy_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      y0_q   <= y0_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = busy_q && last_row;
  assign result_o = acc_q;

endmodule

// File: rtl/fb_scan_addr.sv
// Windowed framebuffer address generator. Scans a rectangular window of an
// H_RES x V_RES frame row by row and emits (x, y, addr) beats on a
// valid/ready stream, with line/frame end flags. Single-shot or continuous,
// with synchronous abort.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : control, window, beat stream and status (slave side)
module fb_scan_addr
  import fb_pkg::*;
#(
  parameter int unsigned H_RES = DefHRes,
  parameter int unsigned V_RES = DefVRes,
  parameter int unsigned XW    = DefXw,
  parameter int unsigned YW    = DefYw,
  parameter int unsigned AW    = DefAw
) (
  input  logic           clk,
  input  logic           reset,
  fb_scan_addr_if.slave  bus
);

  scan_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base_q, base_d;
  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
  logic          cont_q, cont_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          win_ok;
  logic [AW-1:0] row_step;
  logic          calc_start;
  logic          calc_abort;
  logic          calc_busy;
  logic          calc_done;
  logic [AW-1:0] calc_result;
  logic          beat_valid;
  logic          at_x1;
  logic          at_y1;

  assign win_ok = (bus.win_x0 <= bus.win_x1) && (bus.win_y0 <= bus.win_y1) &&
                  (32'(bus.win_x1) < H_RES) && (32'(bus.win_y1) < V_RES);

  // Jump from the last column of one row to the first column of the next.
  assign row_step = AW'(H_RES) - (AW'(x1_q) - AW'(x0_q));

  assign at_x1 = (x_q == x1_q);
  assign at_y1 = (y_q == y1_q);

  fb_base_calc #(
    .H_RES (H_RES),
    .XW    (XW),
    .YW    (YW),
    .AW    (AW)
  ) u_base_calc (
    .clk      (clk),
    .reset    (reset),
    .start_i  (calc_start),
    .abort_i  (calc_abort),
    .x0_i     (bus.win_x0),
    .y0_i     (bus.win_y0),
    .busy_o   (calc_busy),
    .done_o   (calc_done),
    .result_o (calc_result)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    base_d     = base_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    cont_d     = cont_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    calc_start = 1'b0;
    calc_abort = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop is meaningless here, so start always wins.
        if (bus.start) begin
          if (win_ok) begin
            x0_d       = bus.win_x0;
            x1_d       = bus.win_x1;
            y0_d       = bus.win_y0;
            y1_d       = bus.win_y1;
            cont_d     = bus.cont;
            calc_start = 1'b1;
            state_d    = StInit;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      StInit: begin
        if (bus.stop) begin
          calc_abort = 1'b1;
          state_d    = StIdle;
        end else if (calc_done) begin
          base_d  = calc_result;
          addr_d  = calc_result;
          x_d     = x0_q;
          y_d     = y0_q;
          state_d = StRun;
        end
      end

      StRun: begin
        // Abort outranks acceptance: the beat on the bus is dropped.
        if (bus.stop) begin
          state_d = StIdle;
        end else if (bus.addr_ready) begin
          if (!at_x1) begin
            x_d    = x_q + XW'(1);
            addr_d = addr_q + AW'(1);
          end else if (!at_y1) begin
            x_d    = x0_q;
            y_d    = y_q + YW'(1);
            addr_d = addr_q + row_step;
          end else if (cont_q) begin
            x_d    = x0_q;
            y_d    = y0_q;
            addr_d = base_q;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      cont_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      cont_q    <= cont_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign beat_valid     = (state_q == StRun);
  assign bus.addr_valid = beat_valid;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.addr       = addr_q;
  assign bus.line_end   = beat_valid && at_x1;
  assign bus.frame_end  = beat_valid && at_x1 && at_y1;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;

  // Calculator busy mirrors INIT; kept for visibility only.
  logic unused_calc_busy;
  assign unused_calc_busy = calc_busy;

endmodule

// File: tb/tb_fb_scan_addr.sv
// Directed bench for fb_scan_addr with hand-computed expected beats.
module tb_fb_scan_addr;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fb_scan_addr_if #(.XW(DefXw), .YW(DefYw), .AW(DefAw)) bus ();

  fb_scan_addr #(
    .H_RES (DefHRes),
    .V_RES (DefVRes),
    .XW    (DefXw),
    .YW    (DefYw),
    .AW    (DefAw)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input int x0, input int y0, input int x1, input int y1,
                            input logic c);
    bus.win_x0 = DefXw'(x0);
    bus.win_y0 = DefYw'(y0);
    bus.win_x1 = DefXw'(x1);
    bus.win_y1 = DefYw'(y1);
    bus.cont   = c;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (bus.addr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.addr_valid), 1);
  endtask

  // Window (10,5)-(12,6).
  int sm_addr [6] = '{1610, 1611, 1612, 1930, 1931, 1932};
  int sm_x    [6] = '{10, 11, 12, 10, 11, 12};
  int sm_y    [6] = '{5, 5, 5, 6, 6, 6};

  task automatic run_small(input string pfx);
    bus.addr_ready = 1'b1;
    start_scan(10, 5, 12, 6, 1'b0);
    check_eq({pfx, "_busy_k"}, 32'(bus.busy), 1);
    check_eq({pfx, "_valid_k"}, 32'(bus.addr_valid), 0);
    repeat (5) tick();
    check_eq({pfx, "_valid_k5"}, 32'(bus.addr_valid), 0);
    tick();
    check_eq({pfx, "_valid_k6"}, 32'(bus.addr_valid), 1);
    for (int i = 0; i < 6; i++) begin
      check_eq({pfx, "_addr"}, 32'(bus.addr), sm_addr[i]);
      check_eq({pfx, "_x"}, 32'(bus.x), sm_x[i]);
      check_eq({pfx, "_y"}, 32'(bus.y), sm_y[i]);
      check_eq({pfx, "_line_end"}, 32'(bus.line_end), (i == 2 || i == 5) ? 1 : 0);
      check_eq({pfx, "_frame_end"}, 32'(bus.frame_end), (i == 5) ? 1 : 0);
      tick();
    end
    check_eq({pfx, "_valid_end"}, 32'(bus.addr_valid), 0);
    check_eq({pfx, "_busy_end"}, 32'(bus.busy), 0);
    check_eq({pfx, "_done"}, 32'(bus.done), 1);
    tick();
    check_eq({pfx, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  int cont_addr [7] = '{0, 1, 320, 321, 0, 1, 320};

  initial begin
    int i;
    int c;
    logic took;
    int bad_addr, bad_x, bad_y, bad_valid, bad_le, bad_fe, n_le, n_fe;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.cont       = 1'b0;
    bus.stop       = 1'b0;
    bus.win_x0     = '0;
    bus.win_x1     = '0;
    bus.win_y0     = '0;
    bus.win_y1     = '0;
    bus.addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.addr_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_addr", 32'(bus.addr), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_cfg_err", 32'(bus.cfg_err), 0);
    reset = 1'b0;
    tick();

    // Small window, ready high.
    run_small("small");

    // Same window with ready toggling; beats held while stalled.
    bus.addr_ready = 1'b0;
    start_scan(10, 5, 12, 6, 1'b0);
    wait_valid(20, "stall_wait");
    i = 0;
    c = 0;
    while (i < 6 && c < 40) begin
      check_eq("stall_addr", 32'(bus.addr), sm_addr[i]);
      check_eq("stall_x", 32'(bus.x), sm_x[i]);
      check_eq("stall_y", 32'(bus.y), sm_y[i]);
      took = (c % 2 == 0);
      bus.addr_ready = took;
      tick();
      if (took) i++;
      c++;
    end
    check_eq("stall_beats", i, 6);
    check_eq("stall_valid_end", 32'(bus.addr_valid), 0);
    check_eq("stall_done", 32'(bus.done), 1);
    tick();

    // Continuous 2x2 window, then stop.
    bus.addr_ready = 1'b1;
    start_scan(0, 0, 1, 1, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      check_eq("cont_valid", 32'(bus.addr_valid), 1);
      check_eq("cont_addr", 32'(bus.addr), cont_addr[k]);
      check_eq("cont_done", 32'(bus.done), 0);
      tick();
    end
    check_eq("cont_addr_stop", 32'(bus.addr), cont_addr[6]);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_eq("stop_valid", 32'(bus.addr_valid), 0);
    check_eq("stop_busy", 32'(bus.busy), 0);
    check_eq("stop_done", 32'(bus.done), 0);
    tick();
    check_eq("stop_done2", 32'(bus.done), 0);

    // Rejected windows.
    start_scan(5, 0, 4, 0, 1'b0);
    check_eq("cfg_x_err", 32'(bus.cfg_err), 1);
    check_eq("cfg_x_busy", 32'(bus.busy), 0);
    tick();
    check_eq("cfg_x_err_pulse", 32'(bus.cfg_err), 0);
    check_eq("cfg_x_busy2", 32'(bus.busy), 0);
    start_scan(0, 0, 10, 240, 1'b0);
    check_eq("cfg_y_err", 32'(bus.cfg_err), 1);
    check_eq("cfg_y_busy", 32'(bus.busy), 0);
    tick();
    check_eq("cfg_y_err_pulse", 32'(bus.cfg_err), 0);

    // Asynchronous reset in the middle of a scan.
    bus.addr_ready = 1'b1;
    start_scan(10, 5, 12, 6, 1'b0);
    wait_valid(20, "rst_mid_wait");
    tick();
    tick();
    bus.addr_ready = 1'b0;
    tick();
    check_eq("rst_mid_pre_addr", 32'(bus.addr), 1612);
    check_eq("rst_mid_pre_le", 32'(bus.line_end), 1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_valid", 32'(bus.addr_valid), 0);
    check_eq("rst_mid_busy", 32'(bus.busy), 0);
    check_eq("rst_mid_x", 32'(bus.x), 0);
    check_eq("rst_mid_y", 32'(bus.y), 0);
    check_eq("rst_mid_addr", 32'(bus.addr), 0);
    check_eq("rst_mid_le", 32'(bus.line_end), 0);
    check_eq("rst_mid_fe", 32'(bus.frame_end), 0);
    check_eq("rst_mid_done", 32'(bus.done), 0);
    tick();
    reset = 1'b0;
    tick();
    run_small("rerun");

    // Full frame, single shot, ready high.
    bus.addr_ready = 1'b1;
    start_scan(0, 0, 319, 239, 1'b0);
    check_eq("ff_busy", 32'(bus.busy), 1);
    tick();
    bad_addr = 0; bad_x = 0; bad_y = 0; bad_valid = 0; bad_le = 0; bad_fe = 0;
    n_le = 0; n_fe = 0;
    for (int k = 0; k < 76800; k++) begin
      if (bus.addr_valid !== 1'b1) bad_valid++;
      if (32'(bus.addr) !== k) bad_addr++;
      if (32'(bus.x) !== k % 320) bad_x++;
      if (32'(bus.y) !== k / 320) bad_y++;
      if (bus.line_end !== (k % 320 == 319)) bad_le++;
      if (bus.frame_end !== (k == 76799)) bad_fe++;
      if (bus.line_end === 1'b1) n_le++;
      if (bus.frame_end === 1'b1) n_fe++;
      tick();
    end
    check_eq("ff_bad_valid", bad_valid, 0);
    check_eq("ff_bad_addr", bad_addr, 0);
    check_eq("ff_bad_x", bad_x, 0);
    check_eq("ff_bad_y", bad_y, 0);
    check_eq("ff_bad_line_end", bad_le, 0);
    check_eq("ff_bad_frame_end", bad_fe, 0);
    check_eq("ff_n_line_end", n_le, 240);
    check_eq("ff_n_frame_end", n_fe, 1);
    check_eq("ff_valid_end", 32'(bus.addr_valid), 0);
    check_eq("ff_done", 32'(bus.done), 1);
    tick();
    check_eq("ff_done_pulse", 32'(bus.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
